stim_gen: RTL and testbench

//  Synthesizable, parametrised stimulus generator for board-level and simulation bring-up of the NEXYS4_DDR top.

---
 rtl/stim_gen.sv | 159 +++++++++++++++
 tb/tb_stim_gen.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_gen.sv
// stim_gen: parametrised stimulus generator for board/simulation bring-up.
// Drives CH_NUM data channels in counter or pseudo-random mode plus
// STROBE_NUM random strobes, for a bounded or free-running number of cycles.
//
// Control handshake: start_i is a level request that is honoured only in
// IDLE or DONE; stop_i is honoured only in RUN and wins over start_i there.
// valid_o is high for exactly one cycle after every edge that wrote
// data_o/strobe_o (the LOAD edge and each non-stopped RUN edge).
// state_o exposes the FSM state (0=IDLE, 1=LOAD, 2=RUN, 3=DONE).

`timescale 1ns/1ps

module stim_gen #(
   parameter int                 CH_NUM     = 2,
   parameter int                 DW         = 8,
   parameter int                 STEP       = 2,
   parameter int                 LFSR_W     = 32,
   parameter logic [LFSR_W-1:0]  SEED       = 32'hACE12345,
   parameter int                 STROBE_NUM = 2,
   parameter int unsigned        RUN_CYCLES = 140
) (
   input  logic                   CLK100MHZ,
   input  logic                   CPU_RESETN,
   input  logic                   start_i,
   input  logic                   stop_i,
   input  logic                   mode_i,
   input  logic [CH_NUM*DW-1:0]   init_i,
   output logic [CH_NUM*DW-1:0]   data_o,
   output logic [STROBE_NUM-1:0]  strobe_o,
   output logic                   valid_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [31:0]            cycle_cnt_o,
   output logic [1:0]             state_o
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [LFSR_W-1:0] SEED_EFF =
      (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

   // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
   localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(32'h80200003);

   // Counter increment reduced modulo 2^DW.
   localparam logic [DW-1:0] STEP_DW = DW'(STEP);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic                    run_step;
   logic                    mode_q;
   logic [LFSR_W-1:0]       lfsr;
   logic [LFSR_W-1:0]       lfsr_next;
   logic [31:0]             cnt_inc;
   logic [CH_NUM*DW-1:0]    cnt_data;
   logic [CH_NUM*DW-1:0]    rand_data;
   logic [STROBE_NUM-1:0]   strobe_nxt;

   // One Galois step: shift right, fold the outgoing bit back through the taps.
   assign lfsr_next = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? TAPS : '0);

   assign cnt_inc = cycle_cnt_o + 32'd1;

   // Per-channel next values for both modes; the mode register picks one.
   for (genvar c = 0; c < CH_NUM; c++) begin : g_chan
      localparam int ROT   = (7 * c) % LFSR_W;
      localparam int ROT_R = (LFSR_W - ROT) % LFSR_W;

      assign cnt_data[c*DW +: DW]  = data_o[c*DW +: DW] + STEP_DW;
      // Rotating by a channel-dependent amount decorrelates the channels
      // while they all share one LFSR; ROT=0 collapses to x|x = x.
      assign rand_data[c*DW +: DW] = DW'((lfsr_next << ROT) | (lfsr_next >> ROT_R));
   end

   // Strobe i takes bit (LFSR_W-1-i) of the advanced LFSR.
   for (genvar i = 0; i < STROBE_NUM; i++) begin : g_strobe
      assign strobe_nxt[i] = lfsr_next[LFSR_W-1-i];
   end

   // State register.
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; run_step marks an edge that performs a RUN update.
   always_comb begin
      state_nxt = state;
      run_step  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_i) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            state_nxt = S_RUN;
         end
         S_RUN: begin
            if (stop_i) begin
               // Abort: nothing advances, the last written values hold.
               state_nxt = S_DONE;
            end else begin
               run_step = 1'b1;
               if ((RUN_CYCLES != 0) && (cnt_inc == 32'(RUN_CYCLES))) begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (start_i) state_nxt = S_LOAD;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: LOAD re-seeds and loads init values, RUN steps the generator.
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         data_o      <= '0;
         strobe_o    <= '0;
         valid_o     <= 1'b0;
         cycle_cnt_o <= '0;
         lfsr        <= SEED_EFF;
         mode_q      <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         if (state == S_LOAD) begin
            data_o      <= init_i;
            strobe_o    <= '0;
            lfsr        <= SEED_EFF;
            cycle_cnt_o <= '0;
            mode_q      <= mode_i;
            valid_o     <= 1'b1;
         end else if (run_step) begin
            lfsr        <= lfsr_next;
            data_o      <= mode_q ? rand_data : cnt_data;
            strobe_o    <= strobe_nxt;
            // Wraps silently at 2^32 when free-running.
            cycle_cnt_o <= cnt_inc;
            valid_o     <= 1'b1;
         end
      end
   end

   assign busy_o  = (state == S_LOAD) || (state == S_RUN);
   assign done_o  = (state == S_DONE);
   assign state_o = state;

endmodule

// File: tb/tb_stim_gen.sv
// tb_stim_gen: self-checking bench for stim_gen.
// Instance a uses the default (bounded, 140-cycle) configuration; instance b
// is free-running with STEP=255 and SEED=0.

`timescale 1ns/1ps

module tb_stim_gen;

   localparam int RC = 140;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // ---------------- instance a (defaults) ----------------
   logic        start_a, stop_a, mode_a;
   logic [15:0] init_a, data_a;
   logic [1:0]  strobe_a, state_a;
   logic        valid_a, busy_a, done_a;
   logic [31:0] cnt_a;

   stim_gen #(
      .CH_NUM(2), .DW(8), .STEP(2), .LFSR_W(32), .SEED(32'hACE12345),
      .STROBE_NUM(2), .RUN_CYCLES(RC)
   ) u_dut_a (
      .CLK100MHZ(clk), .CPU_RESETN(rst_n),
      .start_i(start_a), .stop_i(stop_a), .mode_i(mode_a), .init_i(init_a),
      .data_o(data_a), .strobe_o(strobe_a), .valid_o(valid_a),
      .busy_o(busy_a), .done_o(done_a), .cycle_cnt_o(cnt_a), .state_o(state_a)
   );

   // ---------------- instance b (free-run, STEP=255, SEED=0) ----------------
   logic        start_b, stop_b, mode_b;
   logic [15:0] init_b, data_b;
   logic [1:0]  strobe_b, state_b;
   logic        valid_b, busy_b, done_b;
   logic [31:0] cnt_b;

   stim_gen #(
      .CH_NUM(2), .DW(8), .STEP(255), .LFSR_W(32), .SEED(32'h0),
      .STROBE_NUM(2), .RUN_CYCLES(0)
   ) u_dut_b (
      .CLK100MHZ(clk), .CPU_RESETN(rst_n),
      .start_i(start_b), .stop_i(stop_b), .mode_i(mode_b), .init_i(init_b),
      .data_o(data_b), .strobe_o(strobe_b), .valid_o(valid_b),
      .busy_o(busy_b), .done_o(done_b), .cycle_cnt_o(cnt_b), .state_o(state_b)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic        valid;
      logic        busy;
      logic        done;
      logic [31:0] cnt;
      logic [15:0] data;
      logic [1:0]  strobe;
   } obs_t;

   localparam int OBS_W = $bits(obs_t);
   logic [OBS_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 32'h0);
   endfunction

   function automatic logic [15:0] rand_word(input logic [31:0] s);
      logic [31:0] r;
      logic [15:0] w;
      for (int c = 0; c < 2; c++) begin
         r = s;
         for (int j = 0; j < (7 * c) % 32; j++) r = {r[30:0], r[31]};
         w[c*8 +: 8] = r[7:0];
      end
      return w;
   endfunction

   function automatic logic [1:0] strobe_of(input logic [31:0] s);
      return {s[30], s[31]};
   endfunction

   function automatic logic [15:0] cnt_word(input logic [15:0] ini, input int k, input int step);
      logic [15:0] w;
      for (int c = 0; c < 2; c++) begin
         w[c*8 +: 8] = 8'((int'(ini[c*8 +: 8]) + k * step) % 256);
      end
      return w;
   endfunction

   function automatic logic [31:0] lfsr_after(input logic [31:0] seed, input int k);
      logic [31:0] s;
      s = (seed == 32'h0) ? 32'h1 : seed;
      for (int j = 0; j < k; j++) s = lfsr_adv(s);
      return s;
   endfunction

   // ---------------- driver: one run on instance a ----------------
   // stop_at >= 0: stop raised after that many updates; rst_at >= 0: reset pulse instead.
   task automatic do_run(input logic md, input logic [15:0] ini, input int stop_at, input int rst_at);
      int          n;
      int          last;
      logic [31:0] s;
      obs_t        e;
      n    = (stop_at >= 0) ? stop_at : RC;
      last = (rst_at >= 0) ? rst_at : n;
      s    = 32'hACE12345;
      exp_q.delete();
      for (int k = 0; k <= last; k++) begin
         if (k > 0) s = lfsr_adv(s);
         e.valid  = 1'b1;
         e.done   = (stop_at < 0) && (k == n);
         e.busy   = !e.done;
         e.cnt    = 32'(k);
         e.data   = (k == 0) ? ini : (md ? rand_word(s) : cnt_word(ini, k, 2));
         e.strobe = (k == 0) ? 2'b00 : strobe_of(s);
         exp_q.push_back(e);
      end
      if (rst_at < 0) begin
         e.valid = 1'b0;
         e.busy  = 1'b0;
         e.done  = 1'b1;
         exp_q.push_back(e);
      end

      start_a = 1'b1; stop_a = 1'b0; mode_a = md; init_a = ini;
      tick();
      check("load state", 64'(state_a), 64'd1);
      check("load busy", 64'(busy_a), 64'd1);
      start_a = 1'b0;

      for (int k = 0; k <= last; k++) begin
         tick();
         e = exp_q.pop_front();
         check($sformatf("run k%0d valid", k), 64'(valid_a), 64'(e.valid));
         check($sformatf("run k%0d busy", k), 64'(busy_a), 64'(e.busy));
         check($sformatf("run k%0d done", k), 64'(done_a), 64'(e.done));
         check($sformatf("run k%0d cnt", k), 64'(cnt_a), 64'(e.cnt));
         check($sformatf("run k%0d data", k), 64'(data_a), 64'(e.data));
         check($sformatf("run k%0d strobe", k), 64'(strobe_a), 64'(e.strobe));
         // mode/init only matter in LOAD; scrambling them afterwards must be harmless.
         mode_a = 1'($urandom_range(0, 1));
         init_a = 16'($urandom);
         if (rst_at == k) begin
            rst_n = 1'b0; start_a = 1'b0; stop_a = 1'b0;
            tick();
            check("mid reset data", 64'(data_a), 64'd0);
            check("mid reset strobe", 64'(strobe_a), 64'd0);
            check("mid reset valid", 64'(valid_a), 64'd0);
            check("mid reset busy", 64'(busy_a), 64'd0);
            check("mid reset done", 64'(done_a), 64'd0);
            check("mid reset cnt", 64'(cnt_a), 64'd0);
            check("mid reset state", 64'(state_a), 64'd0);
            rst_n = 1'b1;
            exp_q.delete();
            return;
         end else if ((stop_at >= 0) && (k == stop_at)) begin
            stop_a  = 1'b1;
            start_a = 1'($urandom_range(0, 1));   // stop must win
         end else if (k < n) begin
            stop_a  = 1'b0;
            start_a = 1'($urandom_range(0, 1));   // ignored in RUN
         end else begin
            start_a = 1'b0;
         end
      end

      tick();
      e = exp_q.pop_front();
      check("end valid", 64'(valid_a), 64'(e.valid));
      check("end busy", 64'(busy_a), 64'(e.busy));
      check("end done", 64'(done_a), 64'(e.done));
      check("end cnt", 64'(cnt_a), 64'(e.cnt));
      check("end data", 64'(data_a), 64'(e.data));
      check("end strobe", 64'(strobe_a), 64'(e.strobe));
      start_a = 1'b0;
      stop_a  = 1'b0;
   endtask

   // ---------------- driver: free run on instance b ----------------
   task automatic free_b(input logic md, input logic [15:0] ini, input int n);
      logic [31:0] s;
      logic [15:0] held;
      s = 32'h1;   // SEED=0 behaves as SEED=1
      start_b = 1'b1; stop_b = 1'b0; mode_b = md; init_b = ini;
      tick();
      start_b = 1'b0;
      for (int k = 0; k <= n; k++) begin
         tick();
         if (k > 0) s = lfsr_adv(s);
         if (s == 32'h0) begin
            n_checks++; n_fail++;
            $display("FAIL model lfsr zero at k%0d", k);
         end
         check($sformatf("free k%0d valid", k), 64'(valid_b), 64'd1);
         check($sformatf("free k%0d done", k), 64'(done_b), 64'd0);
         check($sformatf("free k%0d cnt", k), 64'(cnt_b), 64'(k));
         check($sformatf("free k%0d data", k), 64'(data_b),
               64'((k == 0) ? ini : (md ? rand_word(s) : cnt_word(ini, k, 255))));
         check($sformatf("free k%0d strobe", k), 64'(strobe_b),
               64'((k == 0) ? 2'b00 : strobe_of(s)));
         if (md && (k == 1)) begin
            check("seed0 first data", 64'(data_b), 64'h C003);
            check("seed0 first strobe", 64'(strobe_b), 64'h1);
         end
         mode_b = 1'($urandom_range(0, 1));
         init_b = 16'($urandom);
         stop_b = (k == n);
      end
      held = data_b;
      tick();
      check("free stop done", 64'(done_b), 64'd1);
      check("free stop valid", 64'(valid_b), 64'd0);
      check("free stop cnt", 64'(cnt_b), 64'(n));
      check("free stop data", 64'(data_b), 64'(held));
      stop_b = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        mode;
      logic [15:0] init;
      int          stop_at;
      logic [15:0] exp_data;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] held;

      vecs[0] = '{1'b0, 16'h0100, -1, 16'h1918, 32'd140};
      vecs[1] = '{1'b0, 16'h0100, 10, 16'h1514, 32'd10};
      vecs[2] = '{1'b0, 16'hFFF0, -1, 16'h1708, 32'd140};
      vecs[3] = '{1'b0, 16'h8040,  1, 16'h8242, 32'd1};
      vecs[4] = '{1'b0, 16'h0000,  0, 16'h0000, 32'd0};
      vecs[5] = '{1'b1, 16'h0000,  1, 16'hEBA1, 32'd1};
      vecs[6] = '{1'b1, 16'h1234, -1, rand_word(lfsr_after(32'hACE12345, 140)), 32'd140};
      vecs[7] = '{1'b1, 16'h5678, -1, rand_word(lfsr_after(32'hACE12345, 140)), 32'd140};
      vecs[8] = '{1'b1, 16'h9ABC, 25, rand_word(lfsr_after(32'hACE12345, 25)), 32'd25};

      rst_n = 1'b0;
      start_a = 1'b0; stop_a = 1'b0; mode_a = 1'b0; init_a = 16'h0;
      start_b = 1'b0; stop_b = 1'b0; mode_b = 1'b0; init_b = 16'h0;
      repeat (2) tick();
      check("reset data", 64'(data_a), 64'd0);
      check("reset strobe", 64'(strobe_a), 64'd0);
      check("reset valid", 64'(valid_a), 64'd0);
      check("reset busy", 64'(busy_a), 64'd0);
      check("reset done", 64'(done_a), 64'd0);
      check("reset cnt", 64'(cnt_a), 64'd0);
      check("reset state", 64'(state_a), 64'd0);
      check("reset b state", 64'(state_b), 64'd0);
      rst_n = 1'b1;

      // stop outside RUN is ignored
      stop_a = 1'b1;
      repeat (2) tick();
      check("idle stop state", 64'(state_a), 64'd0);
      check("idle stop valid", 64'(valid_a), 64'd0);
      stop_a = 1'b0;

      for (int i = 0; i < 9; i++) begin
         do_run(vecs[i].mode, vecs[i].init, vecs[i].stop_at, -1);
         check($sformatf("vec%0d data", i), 64'(data_a), 64'(vecs[i].exp_data));
         check($sformatf("vec%0d cnt", i), 64'(cnt_a), 64'(vecs[i].exp_cnt));
         check($sformatf("vec%0d done", i), 64'(done_a), 64'd1);
      end

      // stop held in DONE changes nothing
      held = data_a;
      stop_a = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick();
         check($sformatf("done stop%0d done", j), 64'(done_a), 64'd1);
         check($sformatf("done stop%0d data", j), 64'(data_a), 64'(held));
         check($sformatf("done stop%0d cnt", j), 64'(cnt_a), 64'd25);
         check($sformatf("done stop%0d valid", j), 64'(valid_a), 64'd0);
      end
      stop_a = 1'b0;

      // reset mid-run, then restarts reproduce full runs
      do_run(1'b1, 16'h0000, -1, 50);
      do_run(1'b1, 16'h0000, -1, -1);
      check("rerun rand data", 64'(data_a), 64'(vecs[6].exp_data));
      do_run(1'b0, 16'h0100, -1, 50);
      do_run(1'b0, 16'h0100, -1, -1);
      check("rerun cnt data", 64'(data_a), 64'h1918);

      // free-run: decrement by one for over 300 cycles, then random from seed 1
      free_b(1'b0, 16'h0305, 310);
      free_b(1'b1, 16'h0000, 3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
